// File: rtl/md_unit_pkg.sv
// Shared opcode and state definitions for the multiply/divide unit.
// The control unit imports this package to generate the op field.
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MADD  = 4'd5;
    localparam logic [3:0] MD_MADDU = 4'd6;
    localparam logic [3:0] MD_MSUB  = 4'd7;
    localparam logic [3:0] MD_MSUBU = 4'd8;
    localparam logic [3:0] MD_MTHI  = 4'd9;
    localparam logic [3:0] MD_MTLO  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_t;

    // Ops that occupy the unit for MULT_CYCLES.
    function automatic logic isMulFamily(input logic [3:0] opCode);
        return opCode inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    // Ops that occupy the unit for DIV_CYCLES.
    function automatic logic isDivFamily(input logic [3:0] opCode);
        return opCode inside {MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO for the E stage.
// The result is computed at accept time and held in pending registers;
// the counter only models latency before the result is committed to HI/LO.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    mdState_t         state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [WIDTH-1:0] pendHi, pendHiNext, pendLo, pendLoNext;
    logic             pendCommit, pendCommitNext;
    logic [WIDTH-1:0] hiNext, loNext;
    logic             accept;

    logic [2*WIDTH-1:0] prodSigned, prodUnsigned, product, mulResult;
    logic               signedOp, divByZero, divOverflow;
    logic [WIDTH-1:0]   divisor, quotSigned, remSigned, quotUnsigned, remUnsigned;

    assign accept   = start && (state == IDLE) && !cancel;
    assign busy     = (state == RUN);
    assign signedOp = op inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};

    // Full-width products from explicitly sign- or zero-extended operands.
    assign prodSigned   = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a})
                        * $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
    assign prodUnsigned = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    assign product      = signedOp ? prodSigned : prodUnsigned;

    // Accumulating ops use HI/LO as they stand at accept time; wraps naturally.
    always_comb begin
        unique case (op)
            MD_MADD, MD_MADDU: mulResult = {hi, lo} + product;
            MD_MSUB, MD_MSUBU: mulResult = {hi, lo} - product;
            default:           mulResult = product;
        endcase
    end

    // Dividing by one on both special cases keeps the divider defined: a zero
    // divisor commits nothing anyway, and MIN_INT/1 yields exactly the required
    // overflow result (quotient MIN_INT, remainder 0).
    assign divByZero    = (src_b == '0);
    assign divOverflow  = (op == MD_DIV) && (src_a == MIN_INT) && (src_b == '1);
    assign divisor      = (divByZero || divOverflow) ? ONE : src_b;
    assign quotSigned   = $signed(src_a) / $signed(divisor);
    assign remSigned    = $signed(src_a) % $signed(divisor);
    assign quotUnsigned = src_a / divisor;
    assign remUnsigned  = src_a % divisor;

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        // NOTE: every output of this block gets a hold value first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        stateNext      = state;
        cntNext        = cnt;
        pendHiNext     = pendHi;
        pendLoNext     = pendLo;
        pendCommitNext = pendCommit;
        hiNext         = hi;
        loNext         = lo;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (isMulFamily(op)) begin
                        stateNext                = RUN;
                        cntNext                  = MULT_LOAD;
                        {pendHiNext, pendLoNext} = mulResult;
                        pendCommitNext           = 1'b1;
                    end else if (isDivFamily(op)) begin
                        stateNext      = RUN;
                        cntNext        = DIV_LOAD;
                        pendHiNext     = (op == MD_DIV) ? remSigned  : remUnsigned;
                        pendLoNext     = (op == MD_DIV) ? quotSigned : quotUnsigned;
                        pendCommitNext = !divByZero;
                    end else if (op == MD_MTHI) begin
                        hiNext = src_a;
                    end else if (op == MD_MTLO) begin
                        loNext = src_a;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt == '0) begin
                    stateNext = IDLE;
                    if (pendCommit) begin
                        hiNext = pendHi;
                        loNext = pendLo;
                    end
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, counter, pending and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // values computed above in the same edge, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            // NOTE: the pending registers are reset as well, so nothing stale can
            // ever be committed and simulation never starts from X.
            pendHi     <= '0;
            pendLo     <= '0;
            pendCommit <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            pendHi     <= pendHiNext;
            pendLo     <= pendLoNext;
            pendCommit <= pendCommitNext;
            hi         <= hiNext;
            lo         <= loNext;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: one instance with the default latencies
// and one with single-cycle latencies, driven by the same stimulus.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [3:0]  op;
    logic [31:0] srcA, srcB;
    logic        busyS, busyF;
    logic [31:0] hiS, loS, hiF, loF;

    int nChecks = 0;
    int nPass   = 0;

    // Reference state of HI/LO.
    logic [31:0] mHi, mLo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[15];

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_slow (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(srcA), .src_b(srcB),
        .cancel(cancel), .busy(busyS), .hi(hiS), .lo(loS)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_fast (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(srcA), .src_b(srcB),
        .cancel(cancel), .busy(busyF), .hi(hiF), .lo(loF)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Architectural effect of one accepted op, computed from the arithmetic rules.
    task automatic modelApply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pS, pU, acc;
        pS  = longint'(int'(a)) * longint'(int'(b));
        pU  = {32'b0, a} * {32'b0, b};
        acc = {mHi, mLo};
        case (o)
            MD_MULT:  {mHi, mLo} = pS;
            MD_MULTU: {mHi, mLo} = pU;
            MD_MADD:  {mHi, mLo} = acc + pS;
            MD_MADDU: {mHi, mLo} = acc + pU;
            MD_MSUB:  {mHi, mLo} = acc - pS;
            MD_MSUBU: {mHi, mLo} = acc - pU;
            MD_DIV: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        mLo = a;
                        mHi = 0;
                    end else begin
                        mLo = int'(a) / int'(b);
                        mHi = int'(a) % int'(b);
                    end
                end
            end
            MD_DIVU: begin
                if (b != 0) begin
                    mLo = a / b;
                    mHi = a % b;
                end
            end
            MD_MTHI: mHi = a;
            MD_MTLO: mLo = a;
            default: ;
        endcase
    endtask

    function automatic int expBusy(input logic [3:0] o, input int mulN, input int divN);
        case (o)
            MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return mulN;
            MD_DIV, MD_DIVU: return divN;
            default: return 0;
        endcase
    endfunction

    // Issue one op on both instances, wait for both to go idle, check latency and HI/LO.
    task automatic issueOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int cS = 0;
        int cF = 0;
        int guard = 0;
        op = o; srcA = a; srcB = b; start = 1'b1;
        tick();
        start = 1'b0;
        modelApply(o, a, b);
        while ((busyS || busyF) && guard < 64) begin
            if (busyS) cS++;
            if (busyF) cF++;
            tick();
            guard++;
        end
        if (guard >= 64) check("busy_timeout", 64'(guard), 64'(0));
        check("busy_len_slow", 64'(cS), 64'(expBusy(o, 5, 10)));
        check("busy_len_fast", 64'(cF), 64'(expBusy(o, 1, 1)));
        check("hi_slow", {32'b0, hiS}, {32'b0, mHi});
        check("lo_slow", {32'b0, loS}, {32'b0, mLo});
        check("hi_fast", {32'b0, hiF}, {32'b0, mHi});
        check("lo_fast", {32'b0, loF}, {32'b0, mLo});
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy_slow"}, {63'b0, busyS}, 64'(0));
        check({tag, "_hi_slow"},   {32'b0, hiS},   64'(0));
        check({tag, "_lo_slow"},   {32'b0, loS},   64'(0));
        check({tag, "_busy_fast"}, {63'b0, busyF}, 64'(0));
        check({tag, "_hi_fast"},   {32'b0, hiF},   64'(0));
        check({tag, "_lo_fast"},   {32'b0, loF},   64'(0));
    endtask

    initial begin
        logic [31:0] preHi, preLo;
        int guard;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MD_DIV,   32'd55,        32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{MD_MTHI,  32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFD};
        vecs[5]  = '{MD_MTLO,  32'h5678,      32'd0,        32'h1234,      32'h5678};
        vecs[6]  = '{MD_MADD,  32'd2,         32'd3,        32'h1234,      32'h567E};
        vecs[7]  = '{MD_MSUBU, 32'd1,         32'h567E,     32'h1234,      32'h0};
        vecs[8]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        vecs[9]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vecs[10] = '{MD_MSUB,  32'd1,         32'd1,        32'hFFFF_FFFE, 32'h0};
        vecs[11] = '{MD_MSUBU, 32'd1,         32'd1,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[12] = '{MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0};
        vecs[13] = '{MD_NONE,  32'hDEAD_BEEF, 32'h1,        32'hFFFF_FFFC, 32'h0};
        vecs[14] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,        32'hFFFF_FFFD};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = MD_NONE; srcA = '0; srcB = '0;
        mHi = '0; mLo = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checkAllZero("reset");

        // Table-driven directed vectors, applied in order from the reset state.
        for (int i = 0; i < 15; i++) begin
            issueOp(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_hi", i), {32'b0, hiS}, {32'b0, vecs[i].expHi});
            check($sformatf("vec%0d_lo", i), {32'b0, loS}, {32'b0, vecs[i].expLo});
        end

        // Start while busy (an mtlo) is ignored; only the first op commits.
        op = MD_MULT; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
        tick();
        op = MD_MTLO; srcA = 32'hDEAD; srcB = 32'd0;
        tick();
        start = 1'b0;
        modelApply(MD_MULT, 32'd3, 32'd4);
        guard = 0;
        while ((busyS || busyF) && guard < 64) begin
            tick();
            guard++;
        end
        check("ignore_busy_hi_slow", {32'b0, hiS}, {32'b0, mHi});
        check("ignore_busy_lo_slow", {32'b0, loS}, {32'b0, mLo});
        check("ignore_busy_lo_fast", {32'b0, loF}, {32'b0, mLo});

        // Back-to-back: start on the cycle right after busy falls is accepted.
        op = MD_MTHI; srcA = 32'h99; start = 1'b1;
        tick();
        start = 1'b0;
        modelApply(MD_MTHI, 32'h99, 32'h0);
        check("b2b_hi_slow", {32'b0, hiS}, 64'h99);
        check("b2b_busy_slow", {63'b0, busyS}, 64'(0));

        // Cancel together with an idle start: start ignored.
        op = MD_MTHI; srcA = 32'h77; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_hi", {32'b0, hiS}, {32'b0, mHi});

        // Cancel on the third busy cycle of a div: no commit.
        preHi = hiS; preLo = loS;
        op = MD_DIV; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("cancel_busy_before", {63'b0, busyS}, 64'(1));
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy_after", {63'b0, busyS}, 64'(0));
        check("cancel_hi", {32'b0, hiS}, {32'b0, preHi});
        check("cancel_lo", {32'b0, loS}, {32'b0, preLo});
        tick();
        check("cancel_hi_later", {32'b0, hiS}, {32'b0, preHi});

        // Reset in the middle of an op: everything returns to zero.
        op = MD_MULT; srcA = 32'd5; srcB = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero("rst_midop");
        mHi = '0; mLo = '0;
        tick();
        checkAllZero("rst_after");

        // Randomised ops of every type against the reference model.
        for (int n = 0; n < 10000; n++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            int sel;
            ro  = 4'($urandom_range(0, 10));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 9));
            else if (sel == 3) rb = -32'($urandom_range(1, 9));
            issueOp(ro, ra, rb);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
